// File: rtl/uart_pkg.sv
// UART shared definitions: parity modes, FSM state encodings
// and the parity helper used by both directions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    // Narrow characters arrive zero-extended, so extra zeros do not change it.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive character buffer: head shown combinationally,
// full-buffer pushes dropped and flagged unless a pop frees a slot.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_configurable.sv
// Parameterised UART: shared baud divider, TX and RX framers,
// and a small receive buffer with per-character parity flag.
module uart_configurable
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              tx_busy,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_parity_err,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              rx_frame_err,
    output logic                              rx_overrun,
    output logic [$clog2(RX_FIFO_DEPTH):0]    rx_level
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          rx_tick;

    assign rx_tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) div_cnt <= '0;
        else if (rx_tick) div_cnt <= '0;
        else div_cnt <= div_cnt + DW'(1);
    end

    tx_state_t            tx_state;
    logic [3:0]           tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tick;

    // Bit timer restarts on acceptance so every bit lasts exactly 16 ticks.
    assign tx_tick = rx_tick && (tx_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            if (tx_state == TX_IDLE) tx_cnt <= '0;
            else if (rx_tick) tx_cnt <= tx_cnt + 4'd1;
            unique case (tx_state)
                TX_IDLE: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                        tx_shift <= tx_data;
                        tx_par   <= parity_bit(8'(tx_data), PARITY);
                        tx_state <= TX_START;
                    end
                end
                TX_START: if (tx_tick) begin
                    tx       <= tx_shift[0];
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_bit == 3'(DATA_BITS - 1)) begin
                        tx_bit <= '0;
                        if (PARITY != PAR_NONE) begin
                            tx       <= tx_par;
                            tx_state <= TX_PARITY;
                        end else begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end
                    end else begin
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end
                TX_PARITY: if (tx_tick) begin
                    tx       <= 1'b1;
                    tx_state <= TX_STOP;
                end
                TX_STOP: if (tx_tick) begin
                    if (tx_bit == 3'(STOP_BITS - 1)) begin
                        tx_busy  <= 1'b0;
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_bit <= tx_bit + 3'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_t            rx_state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [3:0]           rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_perr;
    logic                 push;
    logic [DATA_BITS:0]   push_data;
    logic [DATA_BITS:0]   fifo_head;
    logic                 fifo_empty;

    assign rx_perr = (PARITY != PAR_NONE) &&
                     (rx_par_bit != parity_bit(8'(rx_shift), PARITY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par_bit   <= 1'b0;
            push         <= 1'b0;
            push_data    <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            push         <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_tick) rx_cnt <= rx_cnt + 4'd1;
            unique case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                // Half a bit in: still low means a real start bit.
                RX_START: if (rx_tick && rx_cnt == 4'd7) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tick && rx_cnt == 4'd15) begin
                    rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == 3'(DATA_BITS - 1))
                        rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        rx_bit <= rx_bit + 3'd1;
                end
                RX_PARITY: if (rx_tick && rx_cnt == 4'd15) begin
                    rx_par_bit <= rx_sync;
                    rx_state   <= RX_STOP;
                end
                RX_STOP: if (rx_tick && rx_cnt == 4'd15) begin
                    if (rx_sync) begin
                        push      <= 1'b1;
                        push_data <= {rx_perr, rx_shift};
                        rx_state  <= RX_IDLE;
                    end else begin
                        rx_frame_err <= 1'b1;
                        rx_state     <= RX_WAIT;
                    end
                end
                RX_WAIT: if (rx_sync) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (rx_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .overrun   (rx_overrun),
        .level     (rx_level)
    );

    assign rx_valid      = !fifo_empty;
    assign rx_data       = fifo_head[DATA_BITS-1:0];
    assign rx_parity_err = fifo_head[DATA_BITS];

endmodule

// File: tb/tb_uart_configurable.sv
// Bench for uart_configurable: an 8N1 and an 8E1 instance at 16 clocks
// per bit, checked each cycle against a frame-level reference model.
module tb_uart_configurable;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int BIT    = 16;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data_n, tx_data_e, rx_data_n, rx_data_e;
    logic       tx_valid_n, tx_valid_e, tx_ready_n, tx_ready_e;
    logic       tx_n, tx_e, tx_busy_n, tx_busy_e;
    logic       rx_n, rx_e, rx_ready_n, rx_ready_e;
    logic       rx_valid_n, rx_valid_e, rx_parity_err_n, rx_parity_err_e;
    logic       rx_frame_err_n, rx_frame_err_e, rx_overrun_n, rx_overrun_e;
    logic [2:0] rx_level_n, rx_level_e;

    uart_configurable #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH)
    ) dut_n (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .tx(tx_n), .tx_busy(tx_busy_n), .rx(rx_n),
        .rx_data(rx_data_n), .rx_parity_err(rx_parity_err_n),
        .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
        .rx_frame_err(rx_frame_err_n), .rx_overrun(rx_overrun_n),
        .rx_level(rx_level_n)
    );

    uart_configurable #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH)
    ) dut_e (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .tx(tx_e), .tx_busy(tx_busy_e), .rx(rx_e),
        .rx_data(rx_data_e), .rx_parity_err(rx_parity_err_e),
        .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
        .rx_frame_err(rx_frame_err_e), .rx_overrun(rx_overrun_e),
        .rx_level(rx_level_e)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // TX reference: a frame is a list of line levels, each held BIT clocks.
    logic       m_busy, m_ready;
    int         m_j;
    logic [9:0] m_frame;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_j     <= 0;
        end else if (m_busy) begin
            if (m_j == 10 * BIT - 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_j     <= 0;
            end else begin
                m_j <= m_j + 1;
            end
        end else if (m_ready && tx_valid_n) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_j     <= 0;
            m_frame <= {1'b1, tx_data_n, 1'b0};
        end else begin
            m_ready <= 1'b1;
        end
    end

    // RX reference: queues of {parity_err, data}, updated per whole frame.
    logic [8:0] q_n[$];
    logic [8:0] q_e[$];
    logic       set_n = 1'b1;
    logic       set_e = 1'b1;
    logic       chk_en = 1'b0;
    int         fe_tot_n = 0, fe_tot_e = 0, ov_tot_n = 0, ov_tot_e = 0;

    always @(negedge clk) begin
        if (rx_frame_err_n) fe_tot_n++;
        if (rx_frame_err_e) fe_tot_e++;
        if (rx_overrun_n) ov_tot_n++;
        if (rx_overrun_e) ov_tot_e++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_line", tx_n, m_busy ? m_frame[m_j / BIT] : 1'b1);
            check("tx_busy", tx_busy_n, m_busy);
            check("tx_ready", tx_ready_n, m_ready);
            check("tx_e_idle", tx_e, 1);
            if (set_n) begin
                check("rx_valid_n", rx_valid_n, q_n.size() != 0);
                check("rx_level_n", rx_level_n, q_n.size());
                if (q_n.size() != 0)
                    check("rx_head_n", {rx_parity_err_n, rx_data_n}, q_n[0]);
            end
            if (set_e) begin
                check("rx_valid_e", rx_valid_e, q_e.size() != 0);
                check("rx_level_e", rx_level_e, q_e.size());
                if (q_e.size() != 0)
                    check("rx_head_e", {rx_parity_err_e, rx_data_e}, q_e[0]);
            end
        end
    end

    task automatic send_frame(input bit e, input logic [7:0] d,
                              input logic par, input logic stop);
        int          fe0, ov0, nb;
        logic        exp_fe, exp_ov;
        logic [10:0] bits;
        fe0 = e ? fe_tot_e : fe_tot_n;
        ov0 = e ? ov_tot_e : ov_tot_n;
        nb   = e ? 11 : 10;
        bits = e ? {stop, par, d, 1'b0} : {1'b0, stop, d, 1'b0};
        @(negedge clk);
        if (e) set_e = 1'b0;
        else set_n = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (e) rx_e = bits[i];
            else rx_n = bits[i];
            repeat (BIT) @(negedge clk);
        end
        if (e) rx_e = 1'b1;
        else rx_n = 1'b1;
        exp_fe = !stop;
        exp_ov = 1'b0;
        if (stop) begin
            if (e) begin
                if (q_e.size() == DEPTH) exp_ov = 1'b1;
                else q_e.push_back({par != ^d, d});
            end else begin
                if (q_n.size() == DEPTH) exp_ov = 1'b1;
                else q_n.push_back({1'b0, d});
            end
        end
        repeat (4) @(negedge clk);
        check("frame_err_pulses", (e ? fe_tot_e : fe_tot_n) - fe0, exp_fe);
        check("overrun_pulses", (e ? ov_tot_e : ov_tot_n) - ov0, exp_ov);
        if (e) set_e = 1'b1;
        else set_n = 1'b1;
    endtask

    task automatic pop_one(input bit e);
        @(negedge clk);
        if (e) begin set_e = 1'b0; rx_ready_e = 1'b1; end
        else begin set_n = 1'b0; rx_ready_n = 1'b1; end
        @(negedge clk);
        if (e) begin rx_ready_e = 1'b0; void'(q_e.pop_front()); set_e = 1'b1; end
        else begin rx_ready_n = 1'b0; void'(q_n.pop_front()); set_n = 1'b1; end
    endtask

    logic s_tx[170];
    logic s_rdy[170];
    logic b0;
    int   exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   ones, fe0, ov0;

    initial begin
        tx_data_n = '0; tx_data_e = '0;
        tx_valid_n = 1'b0; tx_valid_e = 1'b0;
        rx_n = 1'b1; rx_e = 1'b1;
        rx_ready_n = 1'b0; rx_ready_e = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ready", tx_ready_n, 0);
        check("reset_level", rx_level_n, 0);
        check("reset_rxdata", rx_data_e, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready_n, 1);

        // 8N1 transmit of 0xA5
        tx_data_n = 8'hA5;
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        s_tx[0] = tx_n; s_rdy[0] = tx_ready_n; b0 = tx_busy_n;
        for (int j = 1; j < 170; j++) begin
            @(negedge clk);
            s_tx[j] = tx_n;
            s_rdy[j] = tx_ready_n;
        end
        check("tx_ready_drop", s_rdy[0], 0);
        check("tx_busy_on", b0, 1);
        for (int k = 0; k < 10; k++) begin
            ones = 0;
            for (int j = 0; j < BIT; j++) ones += int'(s_tx[k * BIT + j]);
            check($sformatf("tx_bit%0d", k), ones, exp_bits[k] * BIT);
        end
        check("tx_ready_159", s_rdy[159], 0);
        check("tx_ready_160", s_rdy[160], 1);

        // even parity receive: 0x3C has four ones, parity bit 1 is wrong
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
        check("par_data", rx_data_e, 8'h3C);
        check("par_err_1", rx_parity_err_e, 1);
        pop_one(1'b1);
        send_frame(1'b1, 8'h3C, 1'b0, 1'b1);
        check("par_err_0", rx_parity_err_e, 0);
        pop_one(1'b1);

        // short low glitch
        fe0 = fe_tot_n;
        @(negedge clk);
        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_valid", rx_valid_n, 0);
        check("glitch_fe", fe_tot_n - fe0, 0);

        // stop bit low
        fe0 = fe_tot_n;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        check("fe_pulse", fe_tot_n - fe0, 1);
        check("fe_level", rx_level_n, 0);

        // overrun with rx_ready held low
        for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1);
        ov0 = ov_tot_n;
        send_frame(1'b0, 8'h05, 1'b0, 1'b1);
        check("ovr_level", rx_level_n, 4);
        check("ovr_pulse", ov_tot_n - ov0, 1);
        check("ovr_head", rx_data_n, 8'h01);
        pop_one(1'b0);
        check("pop_head", rx_data_n, 8'h02);

        // reset in the middle of a 0xFF transmit, FIFO still holding data
        @(negedge clk);
        tx_data_n = 8'hFF;
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        repeat (40) @(negedge clk);
        check("midtx_busy", tx_busy_n, 1);
        set_n = 1'b0; set_e = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx", tx_n, 1);
        check("rst_busy", tx_busy_n, 0);
        check("rst_level", rx_level_n, 0);
        check("rst_valid", rx_valid_n, 0);
        q_n.delete();
        q_e.delete();
        @(negedge clk);
        rst_n = 1'b1;
        set_n = 1'b1; set_e = 1'b1;
        @(negedge clk);
        check("rst_ready_back", tx_ready_n, 1);

        // recovery: one more character each way
        tx_data_n = 8'h3C;
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        repeat (170) @(negedge clk);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        check("recover_data", rx_data_n, 8'hC3);
        pop_one(1'b0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
